dsc_mul_sched: RTL and testbench

DSC_MUL_SCHED -- requirements
Module: dsc_mul_sched

---
 rtl/dsc_mul_sched.sv | 110 +++++++++++
 tb/tb_dsc_mul_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_sched.sv
// Sequencer for a multi-cycle dsc_mul core: accepts an operand pair, clears and runs the
// multiplier until it reports ov or a cycle budget expires, then presents the result.
module dsc_mul_sched #(
  parameter int NUM_BITS  = 8,
  parameter int CYC_WIDTH = 20,
  parameter int TIMEOUT   = 70000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [NUM_BITS-1:0]     in_a,
  input  logic [NUM_BITS-1:0]     in_b,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*NUM_BITS-1:0]   out_z,
  output logic [CYC_WIDTH-1:0]    out_cycles,
  output logic                    out_err,
  output logic                    busy,
  output logic                    mul_rst,
  output logic                    mul_en,
  output logic [NUM_BITS-1:0]     mul_a,
  output logic [NUM_BITS-1:0]     mul_b,
  input  logic [2*NUM_BITS-1:0]   mul_z,
  input  logic                    mul_ov
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CYC_WIDTH-1:0] TIMEOUT_C = CYC_WIDTH'(TIMEOUT);
  localparam logic [CYC_WIDTH-1:0] ONE_C     = CYC_WIDTH'(1);

  logic [1:0]           state;
  logic [1:0]           nxt;
  logic [CYC_WIDTH-1:0] cnt;
  logic [CYC_WIDTH-1:0] cnt_inc;
  logic                 zero_op;

  assign cnt_inc = cnt + ONE_C;
  assign zero_op = (in_a == '0) || (in_b == '0);

  // A zero operand short-circuits straight to DONE without touching the multiplier.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (in_valid) nxt = zero_op ? S_DONE : S_CLEAR;
      S_CLEAR: nxt = S_RUN;
      S_RUN:   if (mul_ov || (cnt_inc == TIMEOUT_C)) nxt = S_DONE;
      S_DONE:  if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      mul_rst    <= 1'b1;
      mul_en     <= 1'b0;
      out_z      <= '0;
      out_cycles <= '0;
      out_err    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      cnt        <= '0;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt == S_IDLE);
      busy      <= (nxt != S_IDLE);
      mul_rst   <= (nxt != S_RUN);
      mul_en    <= (nxt == S_RUN);
      out_valid <= (nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mul_a <= in_a;
            mul_b <= in_b;
            if (zero_op) begin
              out_z      <= '0;
              out_cycles <= '0;
              out_err    <= 1'b0;
            end
          end
        end
        S_CLEAR: cnt <= '0;
        S_RUN: begin
          cnt <= cnt_inc;
          // ov takes priority over a timeout landing on the same cycle.
          if (mul_ov) begin
            out_z      <= mul_z;
            out_cycles <= cnt_inc;
            out_err    <= 1'b0;
          end else if (cnt_inc == TIMEOUT_C) begin
            out_z      <= '0;
            out_cycles <= TIMEOUT_C;
            out_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Bench for dsc_mul_sched: multiplier stub with per-operation latency, a cycle-level
// transaction model compared every cycle, and directed literal scenarios.
module tb_dsc_mul_sched;

  localparam int NB  = 8;
  localparam int CW  = 20;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [NB-1:0] in_a = '0;
  logic [NB-1:0] in_b = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*NB-1:0] out_z;
  logic [CW-1:0] out_cycles;
  logic          out_err;
  logic          busy;
  logic          mul_rst;
  logic          mul_en;
  logic [NB-1:0] mul_a;
  logic [NB-1:0] mul_b;
  logic [2*NB-1:0] mul_z;
  logic          mul_ov;

  int checks = 0;
  int failures = 0;
  int stub_lat = 10;
  int scnt = 0;

  dsc_mul_sched #(.NUM_BITS(NB), .CYC_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cycles(out_cycles), .out_err(out_err), .busy(busy),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .mul_ov(mul_ov)
  );

  always #5 clk = ~clk;

  // Multiplier stub: ov on the stub_lat-th enabled cycle (never when stub_lat is 0).
  always @(posedge clk) begin
    if (mul_rst) scnt <= 0;
    else if (mul_en) scnt <= scnt + 1;
  end
  assign mul_ov = mul_en && (stub_lat != 0) && (scnt == stub_lat - 1);
  assign mul_z  = mul_ov ? ({8'h00, mul_a} * {8'h00, mul_b}) : 16'hDEAD;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one pending operation, timing derived from the latency rules.
  int   cyc = 0;
  bit   pend = 0;
  bit   rstf = 0;
  bit   pnz = 0;
  int   acc_t = 0;
  int   pdue = 0;
  int   pcyc = 0;
  logic [15:0] pz = '0;
  logic pe = 1'b0;
  logic [NB-1:0] ma = '0;
  logic [NB-1:0] mb = '0;

  always @(negedge clk) begin
    bit vexp;
    bit enexp;
    cyc++;
    vexp  = pend && (cyc >= pdue);
    enexp = pend && pnz && (cyc >= acc_t + 2) && (cyc < pdue);
    if (rstf) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_z", out_z, 0);
      chk("rst_out_cycles", out_cycles, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_rst", mul_rst, 1);
      chk("rst_mul_en", mul_en, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
    end else begin
      chk("m_out_valid", out_valid, vexp);
      if (vexp) begin
        chk("m_out_z", out_z, pz);
        chk("m_out_cycles", out_cycles, pcyc);
        chk("m_out_err", out_err, pe);
      end
      chk("m_in_ready", in_ready, !pend);
      chk("m_busy", busy, pend);
      chk("m_mul_en", mul_en, enexp);
      chk("m_mul_rst", mul_rst, !enexp);
      chk("m_mul_a", mul_a, ma);
      chk("m_mul_b", mul_b, mb);
    end
    rstf = rst;
    if (rst) begin
      pend = 0; ma = '0; mb = '0;
    end else if (pend) begin
      if (vexp && out_ready) pend = 0;
    end else if (in_valid) begin
      pend = 1; acc_t = cyc; ma = in_a; mb = in_b;
      pnz = (in_a != 0) && (in_b != 0);
      if (!pnz) begin
        pz = 0; pcyc = 0; pe = 0; pdue = cyc + 1;
      end else if (stub_lat == 0 || stub_lat > TMO) begin
        pz = 0; pcyc = TMO; pe = 1; pdue = cyc + TMO + 2;
      end else begin
        pz = 16'(int'(in_a) * int'(in_b)); pcyc = stub_lat; pe = 0; pdue = cyc + stub_lat + 2;
      end
    end
  end

  task automatic start_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input int lat);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", n < 100, 1);
    in_valid = 1'b1; in_a = a; in_b = b; stub_lat = lat;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = NB'($urandom); in_b = NB'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("valid_wait", n < 200, 1);
  endtask

  task automatic release_op(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NB-1:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    start_op(8'd15, 8'd15, 10);
    wait_valid(n);
    chk("d1_latency", n, 12);
    chk("d1_z", out_z, 225);
    chk("d1_cycles", out_cycles, 10);
    chk("d1_err", out_err, 0);
    release_op(0);

    start_op(8'd0, 8'd77, 10);
    wait_valid(n);
    chk("d2_latency", n, 1);
    chk("d2_z", out_z, 0);
    chk("d2_cycles", out_cycles, 0);
    chk("d2_err", out_err, 0);
    release_op(1);

    start_op(8'd3, 8'd4, 0);
    wait_valid(n);
    chk("d3_latency", n, TMO + 2);
    chk("d3_err", out_err, 1);
    chk("d3_z", out_z, 0);
    chk("d3_cycles", out_cycles, TMO);
    release_op(0);
    chk("d3_idle_ready", in_ready, 1);
    chk("d3_idle_busy", busy, 0);

    start_op(8'd2, 8'd5, TMO);
    wait_valid(n);
    chk("d4_z", out_z, 10);
    chk("d4_cycles", out_cycles, TMO);
    chk("d4_err", out_err, 0);
    release_op(0);

    start_op(8'd255, 8'd255, 5);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("d5_valid", out_valid, 1);
      chk("d5_z", out_z, 65025);
      chk("d5_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    release_op(0);

    start_op(8'd9, 8'd9, 10);
    repeat (4) begin @(posedge clk); #1; end
    chk("d6_run_en", mul_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("d6_valid", out_valid, 0);
    chk("d6_en", mul_en, 0);
    chk("d6_busy", busy, 0);
    chk("d6_ready", in_ready, 1);
    rst = 1'b0;
    start_op(8'd2, 8'd3, 4);
    wait_valid(n);
    chk("d6_z", out_z, 6);
    chk("d6_cycles", out_cycles, 4);
    release_op(0);

    for (int i = 0; i < 1000; i++) begin
      a = NB'($urandom_range(1, 255));
      b = NB'($urandom_range(1, 255));
      start_op(a, b, $urandom_range(1, 40));
      wait_valid(n);
      chk("r_err", out_err, 0);
      release_op($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 20; i++) begin
      a = NB'($urandom_range(0, 255));
      b = (i % 2 == 0) ? 8'd0 : NB'($urandom_range(0, 255));
      if (i % 2 == 1) a = 8'd0;
      start_op(a, b, $urandom_range(1, 20));
      wait_valid(n);
      chk("z_latency", n, 1);
      release_op($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
